// File: rtl/control_sequencer_if.sv
// Control bundle between the Mini SRC control sequencer and the datapath:
// instruction/halt inputs plus every per-cycle strobe and the ALU function select.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        stop;
    logic        PCout, MARin, IncPC, PCin;
    logic        Zin, Zlowout, Yin, Cout;
    logic        Read, Write, MDRin, MDRout, IRin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_op;
    logic        run;

    modport master (
        input  IR, stop,
        output PCout, MARin, IncPC, PCin,
        output Zin, Zlowout, Yin, Cout,
        output Read, Write, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output alu_op, run
    );

    modport slave (
        output IR, stop,
        input  PCout, MARin, IncPC, PCin,
        input  Zin, Zlowout, Yin, Cout,
        input  Read, Write, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control-step sequencer for Mini SRC: fetch T0..T2, execute T3..T7,
// with strobes decoded combinationally from the state register and the opcode.
module control_sequencer #(
    parameter int OPW = 5
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        RST_ST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    state_t           state_reg, state_next;
    logic [OPW-1:0]   op;
    logic             is_alu_r, is_alu_i, is_ld, is_ldi, is_st, is_halt, is_addr;

    assign op       = bus.IR[31 -: OPW];
    assign is_alu_r = (op >= OPW'(3))  && (op <= OPW'(11));
    assign is_alu_i = (op >= OPW'(12)) && (op <= OPW'(14));
    assign is_ld    = (op == OPW'(0));
    assign is_ldi   = (op == OPW'(1));
    assign is_st    = (op == OPW'(2));
    assign is_halt  = (op == OPW'(27));
    // ld, ldi and st share the base-plus-offset address computation in T3/T4.
    assign is_addr  = is_ld || is_ldi || is_st;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= RST_ST;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.PCin    = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.Yin     = 1'b0;
        bus.Cout    = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.BAout   = 1'b0;
        bus.alu_op  = 5'b00000;
        bus.run     = (state_reg != RST_ST) && (state_reg != HALT);

        case (state_reg)
            RST_ST: state_next = T0;
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = ALU_ADD;
                state_next = bus.stop ? HALT : T1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_next  = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (is_alu_r || is_alu_i) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    state_next = T4;
                end else if (is_addr) begin
                    bus.Grb    = 1'b1;
                    bus.BAout  = 1'b1;
                    bus.Yin    = 1'b1;
                    state_next = T4;
                end else if (is_halt) begin
                    state_next = HALT;
                end else begin
                    state_next = T0;
                end
            end
            T4: begin
                state_next = T5;
                if (is_alu_r) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_op = 5'(op);
                end else if (is_alu_i) begin
                    bus.Cout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_op = 5'(op);
                end else if (is_addr) begin
                    bus.Cout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_op = ALU_ADD;
                end else begin
                    state_next = T0;
                end
            end
            T5: begin
                state_next = T0;
                if (is_ld || is_st) begin
                    bus.Zlowout = 1'b1;
                    bus.MARin   = 1'b1;
                    state_next  = T6;
                end else if (is_alu_r || is_alu_i || is_ldi) begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                end
            end
            T6: begin
                state_next = T7;
                if (is_ld) begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end else if (is_st) begin
                    // Read stays low so MDR captures the register value from the bus.
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.MDRin = 1'b1;
                end else begin
                    state_next = T0;
                end
            end
            T7: begin
                state_next = T0;
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end else if (is_st) begin
                    bus.Write  = 1'b1;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RST_ST;
        endcase
    end

endmodule
